hazard_ctrl: RTL

- Pipeline sequencer for the 5-stage core.
- Generates stall/flush for the FET->DEC, DEC->EXE, EXE->MEM and MEM->WB pipeline registers, and operand-forwarding selects for the EXE stage.
- Handles load-use hazards, taken branches/jumps resolved in EXE, and multi-cycle data-memory misses.
- Holds post-reset pipeline-sanitise, miss-timeout and performance-counter state.

---
 rtl/hazard_ctrl_if.sv | 31 +++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bundle: register fields and handshakes from the pipeline in,
// stall/flush/forward controls and status out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             ResultSrcE, RegWriteE, RegWriteM, RegWriteW;
  logic             PCSrcE, MissM, MemReadyM;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             miss_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE, RegWriteE, RegWriteM, RegWriteW,
    output PCSrcE, MissM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, miss_err, stall_cnt, flush_cnt
  );

  // RegWriteE is carried for the pipeline's benefit; the sequencer never needs it.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE, RegWriteM, RegWriteW,
    input  PCSrcE, MissM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, miss_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use / redirect / memory-miss stalls and
// flushes, EXE forwarding selects, miss timeout and performance counters.
//
//   state | meaning
//   INIT  | one-cycle bubble flush of unreset pipeline registers
//   RUN   | normal issue, hazard rules active
//   MISS  | waiting on data-memory fill, whole pipe frozen
//   ERR   | fill timed out, frozen until reset
module hazard_ctrl #(
  parameter int WIDTH        = 32,
  parameter int MISS_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  localparam int WAIT_W = (MISS_TIMEOUT > 2) ? $clog2(MISS_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MISS_TIMEOUT - 1);

  if (WIDTH < 1 || MISS_TIMEOUT < 1) begin : g_param_chk
    $error("hazard_ctrl: WIDTH and MISS_TIMEOUT must be positive");
  end

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_MISS, ST_ERR} state_e;

  state_e             state_q;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               miss_err_q;
  logic               mem_stall, hazard_en, lw_stall;

  assign lw_stall = hz.ResultSrcE && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_comb begin
    mem_stall = 1'b0;
    hazard_en = 1'b0;
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushW = 1'b0;
    case (state_q)
      ST_INIT: begin
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
        hz.FlushW = 1'b1;
      end
      ST_RUN:  if (hz.MissM) mem_stall = 1'b1; else hazard_en = 1'b1;
      ST_MISS: if (!hz.MemReadyM) mem_stall = 1'b1; else hazard_en = 1'b1;
      default: mem_stall = 1'b1;
    endcase
    if (mem_stall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end
    // A redirect discards any load-use stall: the dependent instruction is squashed anyway.
    if (hazard_en) begin
      if (hz.PCSrcE) begin
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (lw_stall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end
    end
  end

  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)      hz.ForwardAE = 2'b10;
    else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E) hz.ForwardAE = 2'b01;
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)      hz.ForwardBE = 2'b10;
    else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E) hz.ForwardBE = 2'b01;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.StallF && (state_q == ST_RUN || state_q == ST_MISS) && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (hz.PCSrcE && !mem_stall && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      miss_err_q  <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      case (state_q)
        ST_INIT: state_q <= ST_RUN;
        ST_RUN: begin
          if (hz.MissM) begin
            wait_cnt_q <= '0;
            state_q    <= ST_MISS;
          end
        end
        ST_MISS: begin
          if (hz.MemReadyM) begin
            state_q <= ST_RUN;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q    <= ST_ERR;
            miss_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        default: miss_err_q <= 1'b1;
      endcase
    end
  end

  assign hz.miss_err  = miss_err_q;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
endmodule
